vpu_issue_seq: RTL

Command-driven issuer that feeds the combinational VPU element ALU.
- Accepts one vector command: opcode, two source base addresses, destination base address and length.
- Streams element pairs from a dual-read operand buffer into the ALU at one element per cycle.
- Registers each ALU result and writes it to the destination buffer.
- Sits between the VPU command queue and the ALU and buffer ports. The ALU is instantiated in the parent and wired to the vpu_* ports.

---
 rtl/vpu_pkg.sv | 25 ++
 rtl/vpu_issue_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vpu_pkg.sv
// Shared types for the VPU issue sequencer: opcodes, FSM states and the latched command.
package vpu_pkg;

    localparam int VPU_OP_W   = 4;
    localparam int VPU_ADDR_W = 10;
    localparam int VPU_LEN_W  = 11;

    localparam logic [VPU_OP_W-1:0] OP_ADD    = 4'd0;
    localparam logic [VPU_OP_W-1:0] OP_SUB    = 4'd1;
    localparam logic [VPU_OP_W-1:0] OP_RELU   = 4'd2;
    localparam logic [VPU_OP_W-1:0] OP_MUL    = 4'd3;
    localparam logic [VPU_OP_W-1:0] OP_D_RELU = 4'd4;
    localparam logic [VPU_OP_W-1:0] OP_MOV    = 4'd5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} vpu_state_e;

    typedef struct packed {
        logic [VPU_OP_W-1:0]   opcode;
        logic [VPU_ADDR_W-1:0] src0;
        logic [VPU_ADDR_W-1:0] src1;
        logic [VPU_ADDR_W-1:0] dst;
        logic [VPU_LEN_W-1:0]  len;
    } vpu_cmd_t;

endpackage

// File: rtl/vpu_issue_seq.sv
// Issues one vector command to the element ALU: read (R), execute (E), write (W),
// one element per cycle, then a single-cycle done pulse.
module vpu_issue_seq
    import vpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = VPU_OP_W,
    parameter int ADDR_W = VPU_ADDR_W,
    parameter int LEN_W  = VPU_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    output logic              vpu_start,
    output logic [DATA_W-1:0] vpu_operand0,
    output logic [DATA_W-1:0] vpu_operand1,
    output logic [OP_W-1:0]   vpu_opcode,
    input  logic [DATA_W-1:0] vpu_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    vpu_state_e        state_q, state_d;
    vpu_cmd_t          cmd_q;
    logic [LEN_W-1:0]  rd_idx_q;
    logic [ADDR_W-1:0] wr_idx_q;
    logic [1:0]        vld_pipe;     // [0] = stage E valid, [1] = stage W valid
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              hs;
    logic              last_issue;

    assign hs         = cmd_valid && cmd_ready;
    assign last_issue = (rd_idx_q == cmd_q.len - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = (cmd_len == '0) ? FIN : RUN;
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_issue)
                    state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // last element sits in W with nothing behind it in E
                if (vld_pipe[1] && !vld_pipe[0])
                    state_d = FIN;
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr0     = rd_en ? cmd_q.src0 + rd_idx_q[ADDR_W-1:0] : '0;
    assign rd_addr1     = rd_en ? cmd_q.src1 + rd_idx_q[ADDR_W-1:0] : '0;
    assign vpu_start    = vld_pipe[0];
    assign vpu_operand0 = vld_pipe[0] ? rd_data0 : '0;
    assign vpu_operand1 = vld_pipe[0] ? rd_data1 : '0;
    assign vpu_opcode   = vld_pipe[0] ? cmd_q.opcode : '0;
    assign wr_en        = vld_pipe[1];
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            vld_pipe  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q  <= state_d;
            vld_pipe <= {vld_pipe[0], rd_en};
            if (rd_en)
                rd_idx_q <= rd_idx_q + LEN_W'(1);
            // W-stage registers drop to zero whenever no element is in flight
            if (vld_pipe[0]) begin
                wr_data_q <= vpu_result;
                wr_addr_q <= cmd_q.dst + wr_idx_q;
                wr_idx_q  <= wr_idx_q + ADDR_W'(1);
            end else begin
                wr_data_q <= '0;
                wr_addr_q <= '0;
            end
            if (hs) begin
                cmd_q    <= '{opcode: cmd_opcode, src0: cmd_src0, src1: cmd_src1,
                              dst: cmd_dst, len: cmd_len};
                rd_idx_q <= '0;
                wr_idx_q <= '0;
            end
        end
    end

endmodule
